// File: rtl/display_7_seg_mux.sv
// Time-multiplexed hex 7-segment driver: scans NUM_DIGITS digits with anti-ghost guard, PWM dimming, LZ blanking.
// Latency: outputs are registered, 1 clk behind prescaler/posn; inputs are sampled once per frame.
// Backpressure: none; free-running scan, inputs snapshotted at each frame start.
module display_7_seg_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int GUARD      = 2,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] n,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lz,
    input  logic [3:0]              brightness,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   digit,
    output logic                    frame_start
);
    localparam int PW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int QW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SUB = (CLK_DIV - GUARD) / 16;

    logic [PW-1:0]           presc;
    logic [QW-1:0]           posn;
    logic [4*NUM_DIGITS-1:0] snap_n;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic                    snap_blz;
    logic [3:0]              snap_br;

    logic                    take;
    logic [4*NUM_DIGITS-1:0] cur_n;
    logic [NUM_DIGITS-1:0]   cur_dp;
    logic                    cur_blz;
    logic [3:0]              cur_br;

    logic [NUM_DIGITS-1:0]   lz;
    logic                    zero_run;
    logic [3:0]              nib;
    logic                    pos_dp;
    logic                    pos_lz;
    logic [NUM_DIGITS-1:0]   onehot;
    logic                    in_win;
    logic                    blanked;
    logic                    en;
    logic [6:0]              seg_raw;
    logic                    dp_raw;
    logic [NUM_DIGITS-1:0]   dig_raw;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign take = (presc == '0) && (posn == '0);

    // On the snapshot edge itself the fresh inputs are what the new frame displays
    assign cur_n   = take ? n          : snap_n;
    assign cur_dp  = take ? dp         : snap_dp;
    assign cur_blz = take ? blank_lz   : snap_blz;
    assign cur_br  = take ? brightness : snap_br;

    always_comb begin
        lz       = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (cur_n[4*i +: 4] == 4'h0);
            lz[i]    = zero_run && (i != 0);
        end
    end

    always_comb begin
        nib    = 4'h0;
        pos_dp = 1'b0;
        pos_lz = 1'b0;
        onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(posn) == i) begin
                nib       = cur_n[4*i +: 4];
                pos_dp    = cur_dp[i];
                pos_lz    = lz[i];
                onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        in_win = 1'b0;
        if (int'(presc) >= GUARD) begin
            in_win = (cur_br == 4'd15) ||
                     ((int'(presc) - GUARD) < SUB * (int'(cur_br) + 1));
        end
        blanked = cur_blz && pos_lz;
        en      = in_win && (!blanked || pos_dp);
        seg_raw = (en && !blanked) ? hex7(nib) : 7'h00;
        dp_raw  = en && pos_dp;
        dig_raw = en ? onehot : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc       <= '0;
            posn        <= '0;
            snap_n      <= '0;
            snap_dp     <= '0;
            snap_blz    <= 1'b0;
            snap_br     <= 4'h0;
            frame_start <= 1'b0;
            seg         <= {7{ACTIVE_LOW}};
            dp_out      <= ACTIVE_LOW;
            digit       <= {NUM_DIGITS{ACTIVE_LOW}};
        end else begin
            if (presc == PW'(CLK_DIV - 1)) begin
                presc <= '0;
                posn  <= (posn == QW'(NUM_DIGITS - 1)) ? '0 : posn + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (take) begin
                snap_n   <= n;
                snap_dp  <= dp;
                snap_blz <= blank_lz;
                snap_br  <= brightness;
            end
            frame_start <= take;
            seg         <= seg_raw ^ {7{ACTIVE_LOW}};
            dp_out      <= dp_raw ^ ACTIVE_LOW;
            digit       <= dig_raw ^ {NUM_DIGITS{ACTIVE_LOW}};
        end
    end
endmodule

// File: tb/tb_display_7_seg_mux.sv
// Directed-vector bench: stimulus queues expected lit slots per frame, a monitor pops them as bursts appear.
module tb_display_7_seg_mux;
    localparam int CD = 40;
    localparam int GD = 2;
    localparam int NV = 9;

    typedef struct packed {
        logic [15:0]     n;
        logic [3:0]      dp;
        logic            blz;
        logic [3:0]      br;
        logic [3:0][6:0] seg;
        logic [3:0]      lit;
        logic [7:0]      len;
    } vec_t;

    typedef struct packed {
        logic [7:0]  idx;
        logic [6:0]  seg;
        logic        dp;
        logic [15:0] start;
        logic [7:0]  len;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] n;
    logic [3:0]  dp;
    logic        blank_lz;
    logic [3:0]  brightness;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  digit;
    logic        frame_start;

    logic [3:0]  n1;
    logic        dp1;
    logic        blz1;
    logic [3:0]  br1;
    logic [6:0]  seg1;
    logic        dp_out1;
    logic        digit1;
    logic        fs1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    vec_t vecs[NV];
    vec_t v2222;

    display_7_seg_mux #(.NUM_DIGITS(4), .CLK_DIV(CD), .GUARD(GD), .ACTIVE_LOW(1'b1)) u0 (
        .clk(clk), .reset(reset), .n(n), .dp(dp), .blank_lz(blank_lz), .brightness(brightness),
        .seg(seg), .dp_out(dp_out), .digit(digit), .frame_start(frame_start));

    display_7_seg_mux #(.NUM_DIGITS(1), .CLK_DIV(CD), .GUARD(GD), .ACTIVE_LOW(1'b0)) u1 (
        .clk(clk), .reset(reset), .n(n1), .dp(dp1), .blank_lz(blz1), .brightness(br1),
        .seg(seg1), .dp_out(dp_out1), .digit(digit1), .frame_start(fs1));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] n_, input logic [3:0] dp_, input logic blz_,
                                input logic [3:0] br_, input logic [27:0] segs_,
                                input logic [3:0] lit_, input logic [7:0] len_);
        vec_t v;
        v.n = n_; v.dp = dp_; v.blz = blz_; v.br = br_;
        v.seg = segs_; v.lit = lit_; v.len = len_;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        n = v.n; dp = v.dp; blank_lz = v.blz; brightness = v.br;
    endtask

    task automatic push_frame(input vec_t v, input int nslots);
        exp_t e;
        for (int p = 0; p < nslots; p++) begin
            if (v.lit[p]) begin
                e.idx = 8'(p); e.seg = v.seg[p]; e.dp = v.dp[p];
                e.start = 16'(CD * p + GD); e.len = v.len;
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < 400);
        if (!frame_start) chk("frame_timeout", 0, 1);
    endtask

    // Monitor: one burst per lit slot, timed from the most recent frame_start
    int         t = 0;
    bit         fs_valid = 0;
    bit         in_burst = 0;
    bit         mon_en = 1;
    int         dark_bad = 0;
    int         b_idx, b_start, b_len;
    bit         b_stable;
    logic [6:0] b_seg, seg_h;
    logic       b_dp, dp_h;
    logic [3:0] b_en, en_v;
    exp_t       e_m;

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v == 4'(1 << i)) return i;
        return 99;
    endfunction

    always @(negedge clk) begin
        en_v  = ~digit;
        seg_h = ~seg;
        dp_h  = ~dp_out;
        t     = t + 1;
        if (reset) begin
            in_burst = 0;
            fs_valid = 0;
        end else if (mon_en) begin
            if (frame_start) begin
                if (fs_valid) chk("frame_period", t, 4 * CD);
                t = 0;
                fs_valid = 1;
            end
            if (en_v != 4'h0) begin
                if (!in_burst) begin
                    in_burst = 1; b_en = en_v; b_idx = oh_idx(en_v);
                    b_seg = seg_h; b_dp = dp_h; b_start = t; b_len = 1; b_stable = 1;
                end else begin
                    b_len++;
                    if (en_v != b_en || seg_h != b_seg || dp_h != b_dp) b_stable = 0;
                end
            end else begin
                if (seg_h != 7'h00 || dp_h != 1'b0) dark_bad++;
                if (in_burst) begin
                    in_burst = 0;
                    if (sb_q.size() == 0) begin
                        chk("unexpected_burst_idx", b_idx, -1);
                    end else begin
                        e_m = sb_q.pop_front();
                        chk("slot_idx", b_idx, int'(e_m.idx));
                        chk("slot_seg", int'(b_seg), int'(e_m.seg));
                        chk("slot_dp", int'(b_dp), int'(e_m.dp));
                        chk("slot_start", b_start, int'(e_m.start));
                        chk("slot_len", b_len, int'(e_m.len));
                        chk("slot_stable", int'(b_stable), 1);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int act_cnt, first_on, bad, k;
        vecs[0] = mk(16'h12AF, 4'b0000, 1'b0, 4'd15, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b1111, 8'd38);
        vecs[1] = mk(16'h12AF, 4'b0000, 1'b0, 4'd0,  {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b1111, 8'd2);
        vecs[2] = mk(16'h0030, 4'b1000, 1'b1, 4'd15, {7'h00, 7'h00, 7'h4F, 7'h3F}, 4'b1011, 8'd38);
        vecs[3] = mk(16'h0030, 4'b0000, 1'b0, 4'd15, {7'h3F, 7'h3F, 7'h4F, 7'h3F}, 4'b1111, 8'd38);
        vecs[4] = mk(16'h0000, 4'b0001, 1'b1, 4'd7,  {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0001, 8'd16);
        vecs[5] = mk(16'h4567, 4'b0000, 1'b1, 4'd14, {7'h66, 7'h6D, 7'h7D, 7'h07}, 4'b1111, 8'd30);
        vecs[6] = mk(16'hBCDE, 4'b0101, 1'b0, 4'd15, {7'h7C, 7'h39, 7'h5E, 7'h79}, 4'b1111, 8'd38);
        vecs[7] = mk(16'h0980, 4'b0000, 1'b1, 4'd3,  {7'h00, 7'h6F, 7'h7F, 7'h3F}, 4'b0111, 8'd8);
        vecs[8] = mk(16'h1111, 4'b0000, 1'b0, 4'd15, {7'h06, 7'h06, 7'h06, 7'h06}, 4'b1111, 8'd38);
        v2222   = mk(16'h2222, 4'b0000, 1'b0, 4'd15, {7'h5B, 7'h5B, 7'h5B, 7'h5B}, 4'b1111, 8'd38);

        reset = 1'b1;
        apply(vecs[0]);
        n1 = 4'h0; dp1 = 1'b1; blz1 = 1'b1; br1 = 4'd15;
        repeat (3) @(negedge clk);
        chk("rst_seg", int'(seg), 7'h7F);
        chk("rst_dp_out", int'(dp_out), 1);
        chk("rst_digit", int'(digit), 4'hF);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_u1_seg", int'(seg1), 0);
        chk("rst_u1_digit", int'(digit1), 0);
        chk("rst_u1_dp_out", int'(dp_out1), 0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("first_frame_start", int'(frame_start), 1);
        push_frame(vecs[0], 4);
        #1 apply(vecs[1]);
        for (int i = 1; i < NV; i++) begin
            wait_frame();
            push_frame(vecs[i], 4);
            if (i + 1 < NV) begin
                #1 apply(vecs[i + 1]);
            end
        end

        // Change n while slot 2 of the 1111 frame is on screen
        repeat (90) @(negedge clk);
        #1 n = 16'h2222;
        wait_frame();
        push_frame(v2222, 4);
        wait_frame();
        push_frame(v2222, 2);
        repeat (90) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_seg", int'(seg), 7'h7F);
        chk("midrst_dp_out", int'(dp_out), 1);
        chk("midrst_digit", int'(digit), 4'hF);
        chk("midrst_frame_start", int'(frame_start), 0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_frame_start", int'(frame_start), 1);
        push_frame(v2222, 4);
        wait_frame();
        @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        chk("dark_cycles_lit", dark_bad, 0);
        mon_en = 0;

        // Single-digit, active-high instance
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!fs1 && k < 200);
        chk("u1_frame_seen", int'(fs1), 1);
        chk("u1_digit_at_fs", int'(digit1), 0);
        act_cnt = 0; first_on = -1; bad = 0;
        for (int c = 1; c < CD; c++) begin
            @(negedge clk);
            if (digit1) begin
                act_cnt++;
                if (first_on < 0) first_on = c;
                if (seg1 != 7'h3F || !dp_out1) bad++;
            end else if (seg1 != 7'h00 || dp_out1) begin
                bad++;
            end
            if (fs1) bad++;
        end
        @(negedge clk);
        chk("u1_period_fs", int'(fs1), 1);
        chk("u1_active_cycles", act_cnt, CD - GD);
        chk("u1_first_active", first_on, GD);
        chk("u1_bad_cycles", bad, 0);
        repeat (CD) @(negedge clk);
        chk("u1_period_fs2", int'(fs1), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
